seq_arithmetic_unit: RTL and testbench
======================================

Name: seq_arithmetic_unit

Overview:
- Parametrised, clocked successor to the combinational arithmetic unit.
- Accepts one operation at a time through a valid/ready input handshake. Executes single-cycle ops in one cycle and MUL iteratively, one shift-add step per cycle.
- Holds the result and flags until a valid/ready output handshake completes.
- Sits between the register file/decoder and the writeback stage of the 8-bit CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- OPW, 8, instruction (opcode) field width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- instruction  input  OPW  opcode.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  unit can accept an operation.
- out  output  WIDTH  registered result.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- carry_flag  output  1  carry/borrow/overflow/shifted-out bit.
- parity_flag  output  1  XOR-reduction of out.
- eq_flag  output  1  op1 == op2 at accept.
- gt_flag  output  1  op1 > op2 (unsigned) at accept.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. While rst is high: state=IDLE; out, all flags and out_valid = 0; in_ready=1; internal operand/accumulator registers = 0.
- Reset mid-operation aborts the operation. No result is produced.
- Opcodes: NOP 0, ADD 1, SUB 2, MUL 3, AND 4, OR 5, XOR 6, INC 7 (op1+1), DEC 8 (op1-1), ROR 9, ROL 10, RSH 11, LSH 12 (all by 1 bit, op1), NOT 13 (~op1). Under the macro: DIV 14, MOD 15.
- Unknown opcodes and NOP complete as single-cycle ops with out=0 and carry=0. eq/gt are still computed.
- States: IDLE, MUL_RUN, DIV_RUN (macro only), DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready at clock edge N. op1/op2/instruction are latched and eq/gt are captured at accept. MUL -> MUL_RUN, DIV/MOD -> DIV_RUN, else compute -> DONE.
- Single-cycle ops: out_valid=1 in the cycle after accept (edge N+1 visible).
- MUL_RUN: LSB-first shift-add over a 2*WIDTH accumulator, exactly WIDTH cycles, then -> DONE. out_valid rises WIDTH+1 cycles after accept edge.
  - out = low WIDTH bits of the product.
  - carry = 1 iff high WIDTH bits of the product are nonzero.
- DONE: out_valid=1, in_ready=0. out and flags are stable until out_valid && out_ready, then -> IDLE.
- in_ready is high only in IDLE. There is no accept in the same cycle as the output handshake, so maximum throughput is one op per 2 cycles.
- After the output handshake, out and flags hold their last values; out_valid=0.
- Carry rules:
  - ADD: bit WIDTH of the sum. INC: same rule.
  - SUB: borrow (op1<op2). DEC: borrow (op1==0).
  - ROR/RSH: op1[0]. ROL/LSH: op1[WIDTH-1].
  - Logic ops: 0.
- RSH/LSH fill with 0. ROR/ROL wrap the shifted-out bit.
- Arithmetic wraps modulo 2^WIDTH: ADD 0xFFFF+1 = 0; DEC 0 = 0xFFFF.
- parity_flag = ^out, updated whenever out is loaded.
- in_valid while not in IDLE is ignored. The source must hold its request until in_ready.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- With the macro: opcodes 14/15 enter DIV_RUN, a restoring divider running WIDTH cycles then -> DONE, same latency as MUL.
  - DIV: out = op1/op2. MOD: out = op1%op2. carry=0.
  - op2==0: out = all ones for DIV, op1 for MOD, carry=1; still WIDTH cycles.
- Without the macro: 14/15 are unknown opcodes (out=0, one cycle); the DIV_RUN state and divider logic are absent.

Test Plan:
- Reset then ADD op1=0xFFFF, op2=0x0001, out_ready=1 -> out_valid one cycle after accept, out=0x0000, carry=1, parity=0, eq=0, gt=1.
- MUL op1=0x0100, op2=0x0100 (WIDTH=16) -> out_valid exactly 17 cycles after accept, out=0x0000, carry=1, busy high throughout. Repeat with 5*24 -> out=120, carry=0.
- Factorial 5 chained through MUL/DEC sequence via handshakes -> final product out=0x0078; ROL 0x8001 -> out=0x0003, carry=1; RSH 0x0003 -> out=0x0001, carry=1.
- Backpressure: out_ready=0 for 3 cycles after SUB 3-5 -> out=0xFFFE, carry=1 held stable, in_valid high meanwhile not accepted (in_ready=0), accepted only after the output handshake completes.
- Assert rst asynchronously mid-MUL_RUN (cycle 5) -> out, flags, out_valid = 0 immediately, in_ready=1. A subsequent NOT 0x00FF -> out=0xFF00.
- With SEQ_ALU_DIV_EN: DIV 100/7 -> out=14; MOD 100/7 -> out=2; DIV 9/0 -> out=0xFFFF, carry=1. Without the macro: opcode 14 -> out=0 after one cycle.

Source files
------------

// File: rtl/seq_arithmetic_unit.sv
// seq_arithmetic_unit: clocked arithmetic unit with valid/ready handshakes.
// MUL is an iterative shift-add. DIV/MOD is a restoring divider that is
// present only when SEQ_ALU_DIV_EN is defined.
// Ports:
//   clk, rst                - clock and asynchronous active-high reset
//   op1, op2, instruction   - operands and opcode, taken when in_valid && in_ready
//   in_valid, in_ready      - input handshake (in_ready is high only in IDLE)
//   out, out_valid, out_ready - registered result and output handshake
//   carry_flag, parity_flag - carry/borrow/shifted-out bit, and the XOR of out
//   eq_flag, gt_flag        - op1 == op2 and op1 > op2 (unsigned), captured at accept
//   busy                    - high in any state other than IDLE
module seq_arithmetic_unit #(
    parameter int WIDTH = 16,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [OPW-1:0]   instruction,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             carry_flag,
    output logic             parity_flag,
    output logic             eq_flag,
    output logic             gt_flag,
    output logic             busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] DONE    = 2'd3;
    localparam int CW = $clog2(WIDTH);
    localparam logic [OPW-1:0] OP_ADD = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
    localparam logic [OPW-1:0] OP_MUL = OPW'(3);
    localparam logic [OPW-1:0] OP_AND = OPW'(4);
    localparam logic [OPW-1:0] OP_OR  = OPW'(5);
    localparam logic [OPW-1:0] OP_XOR = OPW'(6);
    localparam logic [OPW-1:0] OP_INC = OPW'(7);
    localparam logic [OPW-1:0] OP_DEC = OPW'(8);
    localparam logic [OPW-1:0] OP_ROR = OPW'(9);
    localparam logic [OPW-1:0] OP_ROL = OPW'(10);
    localparam logic [OPW-1:0] OP_RSH = OPW'(11);
    localparam logic [OPW-1:0] OP_LSH = OPW'(12);
    localparam logic [OPW-1:0] OP_NOT = OPW'(13);
    localparam logic [WIDTH:0] ONE    = (WIDTH+1)'(1);
`ifdef SEQ_ALU_DIV_EN
    localparam logic [1:0] DIV_RUN = 2'd2;
    localparam logic [OPW-1:0] OP_DIV = OPW'(14);
    localparam logic [OPW-1:0] OP_MOD = OPW'(15);
`endif

    logic [1:0]         state;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic               last;

    assign in_ready    = state == IDLE;
    assign out_valid   = state == DONE;
    assign busy        = state != IDLE;
    assign parity_flag = ^out;
    assign last        = cnt == CW'(WIDTH-1);

    // acc = {partial product, remaining multiplier bits}; add into the top half, then shift right.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? a : {WIDTH{1'b0}}};
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0]   b;
    logic [OPW-1:0]     opc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_nxt;
    // acc = {partial remainder, dividend/quotient}. A zero divisor leaves a
    // quotient of all ones and a remainder of op1, which are the required results.
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b};
    assign div_ge  = rem_sh >= {1'b0, b};
    assign div_nxt = {div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (instruction)
            OP_ADD:  {res_c, res} = {1'b0, op1} + {1'b0, op2};
            OP_SUB:  {res_c, res} = {1'b0, op1} - {1'b0, op2};
            OP_AND:  res = op1 & op2;
            OP_OR:   res = op1 | op2;
            OP_XOR:  res = op1 ^ op2;
            OP_INC:  {res_c, res} = {1'b0, op1} + ONE;
            OP_DEC:  {res_c, res} = {1'b0, op1} - ONE;
            OP_ROR:  {res, res_c} = {op1[0], op1};
            OP_ROL:  {res_c, res} = {op1, op1[WIDTH-1]};
            OP_RSH:  {res, res_c} = {1'b0, op1};
            OP_LSH:  {res_c, res} = {op1, 1'b0};
            OP_NOT:  res = ~op1;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            acc        <= '0;
            cnt        <= '0;
            out        <= '0;
            carry_flag <= 1'b0;
            eq_flag    <= 1'b0;
            gt_flag    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            b          <= '0;
            opc        <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a       <= op1;
                    eq_flag <= op1 == op2;
                    gt_flag <= op1 > op2;
                    cnt     <= '0;
                    if (instruction == OP_MUL) begin
                        acc   <= {{WIDTH{1'b0}}, op2};
                        state <= MUL_RUN;
                    end
`ifdef SEQ_ALU_DIV_EN
                    else if (instruction == OP_DIV || instruction == OP_MOD) begin
                        acc   <= {{WIDTH{1'b0}}, op1};
                        b     <= op2;
                        opc   <= instruction;
                        state <= DIV_RUN;
                    end
`endif
                    else begin
                        out        <= res;
                        carry_flag <= res_c;
                        state      <= DONE;
                    end
                end
                MUL_RUN: begin
                    acc <= mul_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        out        <= mul_nxt[WIDTH-1:0];
                        carry_flag <= |mul_nxt[2*WIDTH-1:WIDTH];
                        state      <= DONE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV_RUN: begin
                    acc <= div_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        out        <= opc == OP_DIV ? div_nxt[WIDTH-1:0] : div_nxt[2*WIDTH-1:WIDTH];
                        carry_flag <= b == '0;
                        state      <= DONE;
                    end
                end
`endif
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// tb_seq_arithmetic_unit: directed self-checking bench for seq_arithmetic_unit.
module tb_seq_arithmetic_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] op1 = '0;
    logic [15:0] op2 = '0;
    logic [7:0]  instruction = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        carry_flag, parity_flag, eq_flag, gt_flag, busy;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] n, p;

    seq_arithmetic_unit dut (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .instruction(instruction),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .carry_flag(carry_flag), .parity_flag(parity_flag),
        .eq_flag(eq_flag), .gt_flag(gt_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1; lat counts edges from accept to the first edge seeing out_valid.
    task automatic do_op(input string tag, input logic [7:0] opc, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] eo, input logic ec, input logic ep, input logic eeq,
                         input logic egt, input int elat);
        int lat;
        logic busy_ok;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        op1 = x; op2 = y; instruction = opc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            busy_ok = busy_ok & busy & !in_ready;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_busy"}, 32'(busy_ok & busy), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(eo));
        chk({tag, "_carry"}, 32'(carry_flag), 32'(ec));
        chk({tag, "_parity"}, 32'(parity_flag), 32'(ep));
        chk({tag, "_eq"}, 32'(eq_flag), 32'(eeq));
        chk({tag, "_gt"}, 32'(gt_flag), 32'(egt));
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_hold"}, 32'(out), 32'(eo));
    endtask

    initial begin
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {28'd0, carry_flag, parity_flag, eq_flag, gt_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_wrap", 8'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        do_op("mul_big", 8'd3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 17);
        do_op("mul_120", 8'd3, 16'h0005, 16'h0018, 16'h0078, 1'b0, 1'b0, 1'b0, 1'b0, 17);

        // factorial 5, feeding results back as operands
        do_op("fact_dec4", 8'd8, 16'h0005, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        n = out;
        do_op("fact_mul20", 8'd3, 16'h0005, n, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b1, 17);
        p = out;
        do_op("fact_dec3", 8'd8, n, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        n = out;
        do_op("fact_mul60", 8'd3, p, n, 16'h003C, 1'b0, 1'b0, 1'b0, 1'b1, 17);
        p = out;
        do_op("fact_dec2", 8'd8, n, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        n = out;
        do_op("fact_mul120", 8'd3, p, n, 16'h0078, 1'b0, 1'b0, 1'b0, 1'b1, 17);
        p = out;
        do_op("fact_dec1", 8'd8, n, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        n = out;
        do_op("fact_final", 8'd3, p, n, 16'h0078, 1'b0, 1'b0, 1'b0, 1'b1, 17);

        do_op("rol", 8'd10, 16'h8001, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        do_op("rsh", 8'd11, 16'h0003, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        do_op("ror", 8'd9, 16'h0001, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        do_op("lsh", 8'd12, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        do_op("dec_zero", 8'd8, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        do_op("inc_wrap", 8'd7, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        do_op("and", 8'd4, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("or", 8'd5, 16'h0F00, 16'h0101, 16'h0F01, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        do_op("unknown", 8'hFF, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        do_op("nop", 8'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
`ifdef SEQ_ALU_DIV_EN
        do_op("div", 8'd14, 16'd100, 16'd7, 16'd14, 1'b0, 1'b1, 1'b0, 1'b1, 17);
        do_op("mod", 8'd15, 16'd100, 16'd7, 16'd2, 1'b0, 1'b1, 1'b0, 1'b1, 17);
        do_op("div_zero", 8'd14, 16'd9, 16'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 17);
        do_op("mod_zero", 8'd15, 16'd9, 16'd0, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b1, 17);
`else
        do_op("op14_unknown", 8'd14, 16'd100, 16'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
`endif

        // backpressure: SUB result held while a new request waits
        @(negedge clk);
        op1 = 16'd3; op2 = 16'd5; instruction = 8'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op1 = 16'h0F0F; op2 = 16'h00FF; instruction = 8'd6;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_out", 32'(out), 32'hFFFE);
            chk("bp_carry", 32'(carry_flag), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_out", 32'(out), 32'hFFFE);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_xor_valid", 32'(out_valid), 32'd1);
        chk("bp_xor_out", 32'(out), 32'h0FF0);
        chk("bp_xor_carry", 32'(carry_flag), 32'd0);
        @(negedge clk);

        // asynchronous reset in the middle of a multiply
        op1 = 16'h1234; op2 = 16'h0003; instruction = 8'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_out_prev", 32'(out), 32'h0FF0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_flags", {28'd0, carry_flag, parity_flag, eq_flag, gt_flag}, 32'd0);
        rst = 1'b0;
        do_op("not", 8'd13, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
